// File: rtl/flash_loader.sv
// flash_loader -- write-side loader for the program flash BRAM.
//
// Takes a framed byte stream (valid/ready) from the UART receiver, checks it,
// and writes the image through the BRAM write port (8-bit, byte-addressed).
// The CPU core is held in reset while a load runs and after a failed load.
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, N data bytes, CSUM.
//   The frame is good when (sum of data bytes + CSUM) mod 256 == 0.
//   Byte address 2k is the low byte of 16-bit word k; 2k+1 is the high byte.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   IN_DATA/IN_VALID    received byte and its valid flag
//   IN_READY            byte is taken when IN_VALID && IN_READY
//   WRADDR/DI/WREN/WE   BRAM write port; WE always mirrors WREN
//   CPU_HOLD            holds the CPU in reset
//   LOAD_DONE/LOAD_ERR  sticky result of the last frame
//   ERR_CODE            0 none, 1 bad length, 2 checksum, 3 timeout
//
// Optional build macro FLASH_LOADER_TIMEOUT_EN: adds an inter-byte timeout of
// TIMEOUT_CYC cycles while a frame is in progress (ERR_CODE 3). Without it a
// stalled frame waits forever with CPU_HOLD asserted.

module flash_loader #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned MAX_BYTES   = 2048,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [ADDR_W-1:0] WRADDR,
  output logic [7:0]        DI,
  output logic              WREN,
  output logic              WE,
  output logic              CPU_HOLD,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [1:0]        ERR_CODE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_FIN    = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  localparam logic [1:0]  E_NONE = 2'd0;
  localparam logic [1:0]  E_LEN  = 2'd1;
  localparam logic [1:0]  E_CSUM = 2'd2;
  localparam logic [1:0]  E_TOUT = 2'd3;
  localparam logic [15:0] MAX_N  = 16'(MAX_BYTES);

  state_t      state, state_next;
  logic        ready_q;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] cnt;        // bytes written so far; also the next write address
  logic [7:0]  acc;        // running 8-bit data sum
  logic [1:0]  code_q, code_next;  // failure cause waiting in FAIL
  logic        accept;
  logic [15:0] len_w;
  logic [7:0]  csum_sum;
  logic        in_frame;
  logic        to_hit;

  assign accept   = IN_VALID && ready_q;
  assign len_w    = {len_hi, IN_DATA};
  assign csum_sum = acc + IN_DATA;
  assign in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);

`ifdef FLASH_LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts idle cycles inside a frame; any accepted byte restarts it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   to_cnt <= '0;
    else if (accept || !in_frame) to_cnt <= '0;
    else                       to_cnt <= to_cnt + 1'b1;
  end

  // The edge at the end of the TIMEOUT_CYC-th idle cycle moves to FAIL.
  assign to_hit = in_frame && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next = state;
    code_next  = code_q;
    case (state)
      S_IDLE:   if (accept && IN_DATA == SYNC_BYTE) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_w == 16'd0 || len_w > MAX_N) begin
            state_next = S_FAIL;
            code_next  = E_LEN;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA:   if (accept && (cnt + 16'd1 == len)) state_next = S_CSUM;
      S_CSUM: begin
        if (accept) begin
          if (csum_sum == 8'd0) begin
            state_next = S_FIN;
          end else begin
            state_next = S_FAIL;
            code_next  = E_CSUM;
          end
        end
      end
      S_FIN:    state_next = S_IDLE;
      S_FAIL:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (to_hit) begin
      state_next = S_FAIL;
      code_next  = E_TOUT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      code_q <= E_NONE;
    end else begin
      state  <= state_next;
      code_q <= code_next;
    end
  end

  // Ready is registered so it stays low through reset and rises one cycle
  // after reset releases; afterwards it tracks the state (low in FIN/FAIL).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ready_q <= 1'b0;
    else     ready_q <= (state_next != S_FIN) && (state_next != S_FAIL);
  end

  // Frame bookkeeping and write port
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_hi <= '0;
      len    <= '0;
      cnt    <= '0;
      acc    <= '0;
      WREN   <= 1'b0;
      WRADDR <= '0;
      DI     <= '0;
    end else begin
      WREN <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (IN_DATA == SYNC_BYTE) begin
              cnt <= '0;
              acc <= '0;
            end
          end
          S_LEN_HI: len_hi <= IN_DATA;
          S_LEN_LO: len    <= len_w;
          S_DATA: begin
            // Length was range-checked first, so cnt never exceeds the depth.
            WREN   <= 1'b1;
            WRADDR <= cnt[ADDR_W-1:0];
            DI     <= IN_DATA;
            cnt    <= cnt + 16'd1;
            acc    <= csum_sum;
          end
          default: ;
        endcase
      end
    end
  end

  assign WE       = WREN;
  assign IN_READY = ready_q;

  // Status: cleared by a new SYNC, set on leaving FIN/FAIL. A failure keeps
  // the CPU held; only a good frame releases it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CPU_HOLD  <= 1'b0;
      LOAD_DONE <= 1'b0;
      LOAD_ERR  <= 1'b0;
      ERR_CODE  <= E_NONE;
    end else begin
      if (state == S_IDLE && accept && IN_DATA == SYNC_BYTE) begin
        CPU_HOLD  <= 1'b1;
        LOAD_DONE <= 1'b0;
        LOAD_ERR  <= 1'b0;
        ERR_CODE  <= E_NONE;
      end else if (state == S_FIN) begin
        LOAD_DONE <= 1'b1;
        CPU_HOLD  <= 1'b0;
      end else if (state == S_FAIL) begin
        LOAD_ERR  <= 1'b1;
        ERR_CODE  <= code_q;
      end
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader -- directed self-checking bench for flash_loader.
// Covers reset values, good load, bad checksum, bad lengths, a full 2048-byte
// streamed image after junk, reset mid-frame, and the inter-byte timeout
// (or its absence, depending on FLASH_LOADER_TIMEOUT_EN).

module tb_flash_loader;

`ifdef FLASH_LOADER_TIMEOUT_EN
  localparam int unsigned TO_CYC = 100;
`else
  localparam int unsigned TO_CYC = 1000000;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [10:0] WRADDR;
  logic [7:0]  DI;
  logic        WREN, WE, CPU_HOLD, LOAD_DONE, LOAD_ERR;
  logic [1:0]  ERR_CODE;

  flash_loader #(.ADDR_W(11), .MAX_BYTES(2048), .SYNC_BYTE(8'hA5),
                 .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .WRADDR(WRADDR), .DI(DI), .WREN(WREN), .WE(WE),
    .CPU_HOLD(CPU_HOLD), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR),
    .ERR_CODE(ERR_CODE));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: byte memory model, write count, run of consecutive writes.
  logic [7:0] mem [0:2047];
  int cyc = 0;
  int wr_cnt = 0;
  int run = 0;
  int last_wr_cyc = -10;
  int we_bad = 0;
  logic [10:0] last_addr = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (WE !== WREN) we_bad++;
    if (!RST && WREN === 1'b1) begin
      mem[WRADDR] = DI;
      wr_cnt++;
      last_addr = WRADDR;
      run = (last_wr_cyc == cyc - 1) ? run + 1 : 1;
      last_wr_cyc = cyc;
    end
  end

  // Present a byte and wait for the edge that accepts it; returns #1 after
  // that edge with IN_VALID still high so bytes can follow back-to-back.
  task automatic send(input logic [7:0] b);
    logic r;
    int   t;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    t = 0;
    do begin
      @(negedge CLK);
      r = IN_READY;
      @(posedge CLK);
      t++;
    end while (!r && t < 50);
    if (!r) chk("send_ready_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Good 4-byte frame with per-byte write latency checks.
  task automatic good_frame(input string tag);
    logic [7:0] d [4];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    send(8'hA5); send(8'h00); send(8'h04);
    for (int i = 0; i < 4; i++) begin
      send(d[i]);
      if (i == 0 || i == 3) begin
        chk({tag, "_wren"}, WREN, 1'b1);
        chk({tag, "_di"}, DI, d[i]);
        chk({tag, "_addr"}, WRADDR, i);
      end
    end
    send(8'h56);
    idle(3);
  endtask

  int base;

  initial begin
    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", IN_READY, 0);
    chk("rst_wren", WREN, 0);
    chk("rst_addr", WRADDR, 0);
    chk("rst_di", DI, 0);
    chk("rst_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready_before_edge", IN_READY, 0);
    @(posedge CLK); #1;
    chk("ready_after_edge", IN_READY, 1);

    // Good load
    base = wr_cnt;
    good_frame("good");
    chk("good_writes", wr_cnt - base, 4);
    chk("good_word0", {mem[1], mem[0]}, 16'h2211);
    chk("good_word1", {mem[3], mem[2]}, 16'h4433);
    chk("good_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 5'b0_1_0_00);

    // Bad checksum
    base = wr_cnt;
    send(8'hA5);
    chk("hold_in_frame", CPU_HOLD, 1);
    chk("done_cleared", LOAD_DONE, 0);
    send(8'h00); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h57);
    idle(3);
    chk("csum_writes", wr_cnt - base, 4);
    chk("csum_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 5'b1_0_1_10);

    // Bad length N=2049
    base = wr_cnt;
    send(8'hA5); send(8'h08); send(8'h01);
    idle(3);
    chk("len2049_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 5'b1_0_1_01);
    chk("len2049_writes", wr_cnt - base, 0);
    // Bad length N=0
    send(8'hA5); send(8'h00); send(8'h00);
    idle(3);
    chk("len0_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 5'b1_0_1_01);
    chk("len0_writes", wr_cnt - base, 0);

    // Junk then full-size image, streamed
    send(8'h00); send(8'hFF); send(8'h5A);
    idle(2);
    chk("junk_ignored", {LOAD_ERR, ERR_CODE, IN_READY}, 4'b1_01_1);
    base = wr_cnt;
    send(8'hA5); send(8'h08); send(8'h00);
    for (int i = 0; i < 2048; i++) send(i[7:0]);
    send(8'h00);  // 8 * sum(0..255) is a multiple of 256
    idle(3);
    chk("full_writes", wr_cnt - base, 2048);
    chk("full_last_addr", last_addr, 11'h7FF);
    chk("full_run", run, 2048);
    chk("full_byte_7ff", mem[2047], 8'hFF);
    chk("full_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 5'b0_1_0_00);

    // Reset mid-DATA
    send(8'hA5); send(8'h00); send(8'h04); send(8'h11); send(8'h22);
    chk("mid_wren_pending", WREN, 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_outs", {IN_READY, WREN, CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 0);
    chk("mid_rst_addr", WRADDR, 0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    idle(2);
    base = wr_cnt;
    good_frame("after_rst");
    chk("after_rst_writes", wr_cnt - base, 4);
    chk("after_rst_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 5'b0_1_0_00);

    // Stall inside DATA
    send(8'hA5); send(8'h00); send(8'h04); send(8'h11);
`ifdef FLASH_LOADER_TIMEOUT_EN
    idle(99);
    chk("to_99_ready", IN_READY, 1);
    idle(1);
    chk("to_100_fail", {IN_READY, LOAD_ERR}, 2'b00);
    idle(1);
    chk("to_flags", {CPU_HOLD, LOAD_DONE, LOAD_ERR, ERR_CODE}, 5'b1_0_1_11);
`else
    idle(200);
    chk("stall_hold", {CPU_HOLD, IN_READY, LOAD_ERR, ERR_CODE}, 5'b1_1_0_00);
`endif

    chk("we_eq_wren", we_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Write-side companion of the program flash BRAM. The CPU fetch path only reads that memory; this block writes program images into it.
- Consumes a framed byte stream from the UART receiver over a valid/ready handshake and checks the frame.
- Drives the BRAM simple-dual-port write port, which is 8 bits wide, byte-addressed and 2048 bytes deep.
- Holds the CPU in reset while a load is in progress and after a failed load.

Parameters:
- ADDR_W, 11, byte write-address width (2048 bytes = 1024 x 16-bit words).
- MAX_BYTES, 2048, largest legal image length in bytes.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000000, inter-byte timeout in CLK cycles (used only with FLASH_LOADER_TIMEOUT_EN).

Ports:
- CLK  input  1  single system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- IN_DATA  input  8  received byte.
- IN_VALID  input  1  IN_DATA is valid this cycle.
- IN_READY  output  1  loader accepts a byte; the byte is taken when IN_VALID && IN_READY.
- WRADDR  output  ADDR_W  BRAM write byte address.
- DI  output  8  BRAM write data.
- WREN  output  1  BRAM write-port enable.
- WE  output  1  BRAM byte write enable; always equal to WREN.
- CPU_HOLD  output  1  holds the CPU core in reset.
- LOAD_DONE  output  1  sticky: last frame was loaded successfully.
- LOAD_ERR  output  1  sticky: last frame failed.
- ERR_CODE  output  2  cause of failure: 0 none, 1 bad length, 2 checksum, 3 timeout.

Behaviour:
- Frame format, in order:
  - SYNC_BYTE.
  - LEN_HI, LEN_LO: 16-bit length N in bytes.
  - N data bytes.
  - CSUM byte. The frame is valid when (sum of all N data bytes + CSUM) mod 256 == 0.
- Byte lanes: byte address 2k is the low byte of word k; byte address 2k+1 is the high byte.
- Reset values:
  - FSM in IDLE.
  - IN_READY=0, WREN=WE=0, WRADDR=0, DI=0.
  - CPU_HOLD=0, LOAD_DONE=0, LOAD_ERR=0, ERR_CODE=0.
  - IN_READY rises one cycle after RST deasserts.
- IN_READY is 1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM. It is 0 in the single-cycle FIN and FAIL states.
- FSM states and transitions (one transition per accepted byte unless noted):
  - IDLE:
    - SYNC_BYTE accepted -> LEN_HI. On that edge: CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0, ERR_CODE=0, checksum accumulator=0, address counter=0.
    - Any other byte is dropped; stay in IDLE.
  - LEN_HI -> LEN_LO: latch the high byte of N.
  - LEN_LO:
    - Form N.
    - If N==0 or N>MAX_BYTES -> FAIL with code 1.
    - Otherwise -> DATA.
  - DATA, on each accepted byte:
    - Register a write for the next cycle: WREN=WE=1, DI=byte, WRADDR=counter.
    - counter+1; accumulator += byte (8-bit wrap).
    - After the N-th byte -> CSUM.
  - CSUM:
    - If (acc + byte) mod 256 == 0 -> FIN.
    - Otherwise -> FAIL with code 2.
  - FIN (1 cycle): LOAD_DONE=1, CPU_HOLD=0 on the next edge -> IDLE.
  - FAIL (1 cycle): LOAD_ERR=1, ERR_CODE latched, CPU_HOLD stays 1 -> IDLE.
- Write timing:
  - Write latency is exactly 1 cycle from the accepting edge. WREN is a one-cycle pulse per byte.
  - Back-to-back bytes (IN_VALID held high) produce back-to-back writes at full rate with no stalls.
  - The address counter never wraps, because N<=MAX_BYTES is checked before any data byte.
- No rollback: on a checksum failure, bytes already written stay in the BRAM. The CPU remains held until a later frame completes successfully.
- SYNC_BYTE value inside LEN, DATA or CSUM is treated as an ordinary byte; there is no resync mid-frame.
- Reset mid-frame:
  - Asynchronous return to reset values; any pending write pulse is cancelled and CPU_HOLD drops to 0.
  - Memory contents are undefined for the partial image.
- LOAD_DONE and LOAD_ERR are mutually exclusive and hold their value until the next SYNC_BYTE is accepted.

Optional Feature:
- Macro FLASH_LOADER_TIMEOUT_EN.
- When defined:
  - A counter clears on every accepted byte and counts cycles while the FSM is in LEN_HI, LEN_LO, DATA or CSUM.
  - When it reaches TIMEOUT_CYC -> FAIL with code 3.
  - The counter is inactive in IDLE.
- When not defined:
  - No counter logic exists and ERR_CODE 3 never occurs.
  - A stalled frame waits indefinitely with CPU_HOLD=1.

Test Plan:
- Good load: send A5 00 04 11 22 33 44 and CSUM=0x56.
  - Writes at addresses 0..3 carry data 11,22,33,44, one pulse each, 1 cycle after each accept.
  - Word 0 reads 0x2211, word 1 reads 0x4433.
  - LOAD_DONE=1, CPU_HOLD=0.
- Bad checksum: same frame with CSUM=0x57.
  - LOAD_ERR=1, ERR_CODE=2, CPU_HOLD remains 1.
  - The 4 writes still occurred.
- Bad length: send A5 08 01, i.e. N=2049.
  - FAIL with ERR_CODE=1; no WREN pulse.
  - Repeat with A5 00 00 (N=0): same result.
- Full-size image plus noise: send junk bytes 00 FF 5A before A5, then N=2048 with IN_VALID held high.
  - Junk is ignored.
  - 2048 consecutive writes, last WRADDR=0x7FF; no wrap, no stall.
- Reset mid-DATA: assert RST after byte 2 of a 4-byte frame.
  - All outputs return to reset values immediately, CPU_HOLD=0.
  - A following good frame loads normally.
- With FLASH_LOADER_TIMEOUT_EN and TIMEOUT_CYC=100: send A5 00 04 11, then idle.
  - FAIL at the 100th idle cycle with ERR_CODE=3.
  - Without the macro, the same stimulus stays in DATA and CPU_HOLD remains 1.
